// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad row scanner with press/release debounce and a one-entry event buffer.
// Optional build macro AUTOREPEAT_EN adds periodic repeat events while a key is held.
`timescale 1ns/1ps
`default_nettype none

module keypad_scan_ctrl #(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam int DW = $clog2(SCAN_CYCLES);
  localparam int BW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [3:0]      meta_q;
  logic [3:0]      csync_q;
  logic [3:0]      row_q;
  logic [DW-1:0]   dwell_q;
  logic [BW-1:0]   db_q;
  logic [1:0]      cap_col_q;
  logic [3:0]      key_code_q;
  logic            valid_q;
  logic            held_q;
  logic            overrun_q;

  logic            col_onehot;
  logic            col_match;
  logic            cap_bit;
  logic            rpt_fire;
  logic            emit;
  logic            xfer;
  logic [1:0]      row_idx;

  function automatic logic [1:0] enc4(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[1]) idx = 2'd1;
    if (v[2]) idx = 2'd2;
    if (v[3]) idx = 2'd3;
    return idx;
  endfunction

  assign col_onehot = (csync_q != 4'b0000) && ((csync_q & (csync_q - 4'd1)) == 4'b0000);
  assign col_match  = (csync_q == (4'b0001 << cap_col_q));
  assign cap_bit    = csync_q[cap_col_q];
  assign row_idx    = enc4(row_q);
  assign xfer       = valid_q && key_ready;
  assign emit       = ((state_q == DEBOUNCE) && col_match && (db_q == DB_LAST)) || rpt_fire;

`ifdef AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rpt_q;

  assign rpt_fire = (state_q == HELD) && cap_bit && (rpt_q == RPT_LAST);

  // Held outside HELD at zero, so every entry into HELD starts a fresh interval.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_q <= '0;
    end else if ((state_q != HELD) || rpt_fire) begin
      rpt_q <= '0;
    end else if (rpt_q != RPT_LAST) begin
      rpt_q <= rpt_q + 1'b1;
    end
  end
`else
  if (REPEAT_CYCLES > 0) begin : g_no_repeat
    assign rpt_fire = 1'b0;
  end else begin : g_no_repeat_z
    assign rpt_fire = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SCAN;
      meta_q     <= 4'b0000;
      csync_q    <= 4'b0000;
      row_q      <= 4'b0001;
      dwell_q    <= '0;
      db_q       <= '0;
      cap_col_q  <= 2'd0;
      key_code_q <= 4'h0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      meta_q  <= col;
      csync_q <= meta_q;

      // A transfer in the same cycle frees the slot, so the new event is not an overrun.
      if (emit) begin
        if (!valid_q || xfer) begin
          key_code_q <= {row_idx, cap_col_q};
          valid_q    <= 1'b1;
        end else begin
          overrun_q  <= 1'b1;
        end
      end else if (xfer) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        SCAN: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_q <= '0;
            if (col_onehot) begin
              cap_col_q <= enc4(csync_q);
              db_q      <= '0;
              state_q   <= DEBOUNCE;
            end else begin
              row_q <= {row_q[2:0], row_q[3]};
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!col_match) begin
            state_q <= SCAN;
            dwell_q <= '0;
            db_q    <= '0;
          end else if (db_q == DB_LAST) begin
            state_q <= HELD;
            held_q  <= 1'b1;
            db_q    <= '0;
          end else begin
            db_q <= db_q + 1'b1;
          end
        end
        HELD: begin
          if (!cap_bit) begin
            state_q <= RELEASE;
            db_q    <= '0;
          end
        end
        RELEASE: begin
          if (cap_bit) begin
            state_q <= HELD;
            db_q    <= '0;
          end else if (db_q == DB_LAST) begin
            state_q <= SCAN;
            held_q  <= 1'b0;
            row_q   <= {row_q[2:0], row_q[3]};
            dwell_q <= '0;
            db_q    <= '0;
          end else begin
            db_q <= db_q + 1'b1;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed self-checking bench for keypad_scan_ctrl.
// Build with AUTOREPEAT_EN defined to exercise the repeat events.
`timescale 1ns/1ps
`default_nettype none

module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_ready = 1'b0;
  logic [3:0] col = 4'b0000;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       overrun;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_xfer = 0;
  logic held_before;

  keypad_scan_ctrl #(
    .SCAN_CYCLES(2),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .col(col),
    .row(row),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held(key_held),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (key_valid && key_ready) n_xfer <= n_xfer + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stops on the negedge right after the row pointer moves onto tgt.
  task automatic wait_row_enter(input logic [3:0] tgt);
    logic [3:0] prev;
    bit found;
    prev  = row;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (row == tgt && prev != tgt) found = 1'b1;
      prev = row;
    end
    chk("wait_row", 32'(found), 32'd1);
  endtask

  // Column goes up on the last dwell cycle of the preceding row, so after the
  // 2-flop synchronizer it is seen at the decision point of row r.
  task automatic press_key(input int r, input int c);
    logic [3:0] prev_row;
    prev_row = 4'b0001 << ((r + 3) % 4);
    wait_row_enter(prev_row);
    tick(1);
    col = 4'b0001 << c;
    tick(10);
    held_before = key_held;
    tick(1);
  endtask

  task automatic release_key();
    col = 4'b0000;
    tick(10);
    held_before = key_held;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] rot_exp [4];
    logic [3:0] prev;
    int x0;
    int changes;
    logic v_seen;
    rot_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // 1: reset and free-running rotation
    tick(3);
    chk("t1_row_in_rst", 32'(row), 32'h1);
    reset = 1'b1;
    chk("t1_row_rst", 32'(row), 32'h1);
    chk("t1_outs_rst", {25'd0, key_valid, key_held, overrun, key_code}, 32'h0);
    tick(1);
    chk("t1_row_dwell", 32'(row), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick(2);
      chk("t1_rot", 32'(row), 32'(rot_exp[i]));
    end
    chk("t1_outs_idle", {29'd0, key_valid, key_held, overrun}, 32'h0);

    // 2: single press of key 9, consumer always ready
    key_ready = 1'b1;
    x0 = n_xfer;
    press_key(2, 1);
    chk("t2_held_pre", 32'(held_before), 32'd0);
    chk("t2_valid", 32'(key_valid), 32'd1);
    chk("t2_code", 32'(key_code), 32'h9);
    chk("t2_held", 32'(key_held), 32'd1);
    chk("t2_row_frozen", 32'(row), 32'h4);
    tick(1);
    chk("t2_valid_drop", 32'(key_valid), 32'd0);
    chk("t2_held_stay", 32'(key_held), 32'd1);
    release_key();
    chk("t2_held_rel_pre", 32'(held_before), 32'd1);
    chk("t2_held_rel", 32'(key_held), 32'd0);
    chk("t2_row_next", 32'(row), 32'h8);
    tick(6);
    chk("t2_one_event", 32'(n_xfer - x0), 32'd1);

    // 3: short glitch on key 0 is rejected
    wait_row_enter(4'b1000);
    tick(1);
    col = 4'b0001;
    tick(5);
    chk("t3_row_frozen", 32'(row), 32'h1);
    chk("t3_no_valid", 32'(key_valid), 32'd0);
    col = 4'b0000;
    tick(3);
    chk("t3_row_same", 32'(row), 32'h1);
    chk("t3_no_held", {30'd0, key_valid, key_held}, 32'h0);
    tick(2);
    chk("t3_resume", 32'(row), 32'h2);

    // 4: overrun with a stalled consumer
    key_ready = 1'b0;
    press_key(0, 0);
    chk("t4_k0_valid", 32'(key_valid), 32'd1);
    chk("t4_k0_code", 32'(key_code), 32'h0);
    chk("t4_k0_ovr", 32'(overrun), 32'd0);
    release_key();
    chk("t4_k0_rel_row", 32'(row), 32'h2);
    press_key(3, 3);
    chk("t4_k15_valid", 32'(key_valid), 32'd1);
    chk("t4_k15_code_kept", 32'(key_code), 32'h0);
    chk("t4_k15_ovr", 32'(overrun), 32'd1);
    chk("t4_k15_held", 32'(key_held), 32'd1);
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
    chk("t4_xfer_valid", 32'(key_valid), 32'd0);
    chk("t4_ovr_sticky", 32'(overrun), 32'd1);
    chk("t4_code_hold", 32'(key_code), 32'h0);
    release_key();
    chk("t4_k15_rel_row", 32'(row), 32'h1);

    // 5: two columns at once never produce an event
    col = 4'b0110;
    prev = row;
    changes = 0;
    v_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (row != prev) changes++;
      v_seen = v_seen | key_valid;
      prev = row;
    end
    chk("t5_rotations", 32'(changes), 32'd25);
    chk("t5_no_event", 32'(v_seen), 32'd0);
    col = 4'b0000;
    tick(3);

    // 5b: asynchronous reset in the middle of DEBOUNCE
    wait_row_enter(4'b0001);
    tick(1);
    col = 4'b0010;
    tick(5);
    chk("t5_db_frozen", 32'(row), 32'h2);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_row", 32'(row), 32'h1);
    chk("t5_rst_outs", {25'd0, key_valid, key_held, overrun, key_code}, 32'h0);
    col = 4'b0000;
    @(negedge clk);
    reset = 1'b1;

    // 6: key 5 held for 60 cycles
    key_ready = 1'b1;
    x0 = n_xfer;
    press_key(1, 1);
    chk("t6_first_valid", 32'(key_valid), 32'd1);
    chk("t6_first_code", 32'(key_code), 32'h5);
    tick(15);
    chk("t6_gap", 32'(key_valid), 32'd0);
    tick(1);
`ifdef AUTOREPEAT_EN
    chk("t6_repeat_valid", 32'(key_valid), 32'd1);
    chk("t6_repeat_code", 32'(key_code), 32'h5);
`else
    chk("t6_no_repeat", 32'(key_valid), 32'd0);
`endif
    tick(44);
`ifdef AUTOREPEAT_EN
    chk("t6_event_count", 32'(n_xfer - x0), 32'd4);
`else
    chk("t6_event_count", 32'(n_xfer - x0), 32'd1);
`endif
    chk("t6_held", 32'(key_held), 32'd1);
    release_key();
    chk("t6_released", 32'(key_held), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan sequencer for the 4x4 matrix keypad. Drives one-hot rows and samples the four column lines. Debounces press and release, then delivers exactly one key event per press to the display/LED logic over a valid/ready handshake. It replaces ad-hoc per-row state enumeration with a row pointer plus a small control FSM.

Parameters:
SCAN_CYCLES, 4, clock cycles each row is driven before its columns are sampled (settling time); legal values are 2 or more.
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or a release; legal values are 2 or more.
REPEAT_CYCLES, 500000, auto-repeat interval; used only when AUTOREPEAT_EN is defined.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset (reset==0 resets the block).
col  in  4  raw column inputs; active-high; asynchronous to clk.
row  out  4  one-hot row drive; active-high.
key_code  out  4  {row_idx[1:0], col_idx[1:0]}, so row r, column c gives r*4+c.
key_valid  out  1  key event pending.
key_ready  in  1  consumer accepts the event; a transfer happens on a cycle where key_valid and key_ready are both high.
key_held  out  1  a debounced key is currently down.
overrun  out  1  sticky flag: an event was dropped because the previous event was still pending.

Behaviour:
- Reset (async assert, release sampled on clk): row=4'b0001, key_code=0, key_valid=0, key_held=0, overrun=0. FSM=SCAN. All counters and sync flops are 0. Asserting reset mid-operation forces these values immediately.
- col passes through a 2-flop synchronizer; the result is csync. All decisions use csync only.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - A dwell counter counts 0..SCAN_CYCLES-1 for the current row.
  - On the last dwell cycle, if csync has exactly one bit set: capture row_idx and col_idx and go to DEBOUNCE. The row stays frozen.
  - Otherwise (zero bits, or two or more bits): rotate row left (0001->0010->0100->1000->0001), clear dwell, stay in SCAN.
  - Multi-key on one row is ignored, not reported.
- DEBOUNCE:
  - The debounce counter increments each cycle that csync equals the captured one-hot column.
  - Any mismatch: return to SCAN on the same row with dwell cleared. No event.
  - On the cycle the counter reaches DEBOUNCE_CYCLES-1: go to HELD and emit an event. key_valid and key_held rise on the next edge, i.e. DEBOUNCE_CYCLES cycles after DEBOUNCE was entered.
- HELD:
  - key_held=1 and the row stays frozen.
  - Stay while the captured column bit of csync is 1; other column bits are ignored.
  - When the captured bit reads 0: go to RELEASE with the counter cleared.
- RELEASE:
  - The counter increments while the captured bit is 0.
  - If the bit returns to 1: go back to HELD, counter cleared, no new event.
  - When the counter reaches DEBOUNCE_CYCLES-1: go to SCAN, key_held falls, row advances to the next row, dwell cleared.
- Event buffer (one entry):
  - Emitting with key_valid=0 loads key_code and sets key_valid.
  - Emitting with key_valid=1 (and no transfer that same cycle) keeps the pending code and sets overrun.
  - Emitting on the same cycle as a transfer loads the new code and leaves key_valid=1.
  - key_valid clears on a transfer; key_code holds its last value.
  - overrun clears only on reset.
- Counters are sized with $clog2 of their parameter and never wrap: they saturate at the terminal count.

Optional Feature:
AUTOREPEAT_EN
- Defined: while in HELD, a repeat counter counts cycles. After REPEAT_CYCLES cycles it emits the same key_code (same buffer rules, including overrun) and restarts, repeating every REPEAT_CYCLES cycles until the key leaves HELD. The counter clears whenever HELD is entered, including a return from RELEASE.
- Not defined: the repeat logic is absent and exactly one event is produced per press.

Test Plan:
(All scenarios use SCAN_CYCLES=2, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=16.)
1. Hold reset low, then release with col=0: row reads 0001 out of reset. Row then steps 0010, 0100, 1000, 0001 every 2 cycles. All other outputs stay 0.
2. Hold col=4'b0010 while row=0100, key_ready=1: key_valid pulses once with key_code=4'h9 and key_held=1. Release col: key_held falls 8 stable cycles later and scanning resumes at row 1000. Only one event occurs.
3. Drive col=0001 on row 0001 for 5 cycles (the 2 sync cycles plus a short DEBOUNCE stretch), then 0: no key_valid, and scanning resumes on row 0001.
4. With key_ready=0, press and release key 0, then press key 15: key_valid stays high with key_code=0 and overrun=1. Then raise key_ready for 1 cycle: key_valid falls and overrun stays 1.
5. Drive col=4'b0110 on row 0010 for 50 cycles: no event and row keeps rotating. Separately, assert reset during DEBOUNCE: row=0001 and all outputs are 0 immediately.
6. With AUTOREPEAT_EN defined, hold key 5 for 60 cycles with key_ready=1: the first event arrives, then repeat events follow every 16 cycles with key_code=4'h5. Without the macro, only the first event appears.
